// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor: run-control and trace monitor for a pipelined core.
// Counts enabled cycles and retirements, stops the run on a cycle limit,
// a halt instruction or a stuck PC, and keeps the most recent writebacks
// in a circular trace buffer with a registered age-indexed read port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en_i, clear_i     run enable, synchronous clear to post-reset state
//   pc_i, instr_i     core PC and fetched instruction
//   alu_i, wb_i       core ALU result and writeback data
//   wb_valid_i        writeback/retire qualifier
//   rd_addr_i         trace age index (0 = newest)
//   rd_*_o            addressed trace entry (1-cycle latency), rd_valid_o
//   cycle_cnt_o       enabled cycles counted in RUN
//   retire_cnt_o      captured writebacks
//   trace_cnt_o       valid trace entries, saturating at DEPTH
//   done_o            sticky run-stopped flag
//   done_cause_o      0 none, 1 cycle limit, 2 halt word, 3 stuck PC
module pipe_run_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MAX_CYCLES  = 200,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'hFFFF_FFFF),
  parameter int unsigned STUCK_LIMIT = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned TW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wb_i,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_pc_o,
  output logic [DATA_W-1:0] rd_wb_o,
  output logic [DATA_W-1:0] rd_alu_o,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic [TW-1:0]     trace_cnt_o,
  output logic              done_o,
  output logic [1:0]        done_cause_o
);

  localparam int unsigned SW = $clog2(STUCK_LIMIT) + 1;

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cause_nxt;

  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] prev_pc;
  logic              prev_valid;
  logic [SW-1:0]     stuck_cnt;

  logic [DATA_W-1:0] mem_pc  [DEPTH];
  logic [DATA_W-1:0] mem_alu [DEPTH];
  logic [DATA_W-1:0] mem_wb  [DEPTH];

  logic              active;
  logic [CNT_W-1:0]  cyc_nxt;
  logic [SW-1:0]     stuck_nxt;
  logic              hit_halt, hit_stuck, hit_lim;
  logic [AW-1:0]     rd_idx;
  logic              rd_hit;

  // Per-cycle qualifiers and stop-condition detection
  always_comb begin
    active    = (state == RUN) && en_i && !clear_i;
    cyc_nxt   = cycle_cnt_o + CNT_W'(1);
    stuck_nxt = (prev_valid && (pc_i == prev_pc)) ? stuck_cnt + SW'(1) : '0;
    hit_halt  = (instr_i == HALT_WORD);
    hit_stuck = (stuck_nxt == SW'(STUCK_LIMIT - 1));
    hit_lim   = (cyc_nxt == CNT_W'(MAX_CYCLES));
    rd_idx    = wr_ptr - AW'(1) - rd_addr_i;
    rd_hit    = ({1'b0, rd_addr_i} < trace_cnt_o);
  end

  // Next-state and stop cause; halt > stuck > cycle limit
  always_comb begin
    state_nxt = state;
    cause_nxt = done_cause_o;
    if (clear_i) begin
      state_nxt = RUN;
      cause_nxt = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (active) begin
            if (hit_halt) begin
              state_nxt = DONE;
              cause_nxt = 2'd2;
            end else if (hit_stuck) begin
              state_nxt = DONE;
              cause_nxt = 2'd3;
            end else if (hit_lim) begin
              state_nxt = DONE;
              cause_nxt = 2'd1;
            end
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register and registered run status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      done_o       <= 1'b0;
      done_cause_o <= 2'd0;
    end else begin
      state        <= state_nxt;
      done_o       <= (state_nxt == DONE);
      done_cause_o <= cause_nxt;
    end
  end

  // Counters, write pointer and stuck-PC tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_o  <= '0;
      retire_cnt_o <= '0;
      trace_cnt_o  <= '0;
      wr_ptr       <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      stuck_cnt    <= '0;
    end else if (clear_i) begin
      cycle_cnt_o  <= '0;
      retire_cnt_o <= '0;
      trace_cnt_o  <= '0;
      wr_ptr       <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      stuck_cnt    <= '0;
    end else if (active) begin
      cycle_cnt_o <= cyc_nxt;
      prev_pc     <= pc_i;
      prev_valid  <= 1'b1;
      stuck_cnt   <= stuck_nxt;
      if (wb_valid_i) begin
        wr_ptr       <= wr_ptr + AW'(1);
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
        if (trace_cnt_o != TW'(DEPTH)) begin
          trace_cnt_o <= trace_cnt_o + TW'(1);
        end
      end
    end
  end

  // Trace storage; contents need no reset since trace_cnt gates reads
  always_ff @(posedge clk) begin
    if (active && wb_valid_i) begin
      mem_pc[wr_ptr]  <= pc_i;
      mem_alu[wr_ptr] <= alu_i;
      mem_wb[wr_ptr]  <= wb_i;
    end
  end

  // Registered read port, indexed by age from the pre-edge write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_o <= 1'b0;
      rd_pc_o    <= '0;
      rd_alu_o   <= '0;
      rd_wb_o    <= '0;
    end else begin
      rd_valid_o <= rd_hit;
      rd_pc_o    <= rd_hit ? mem_pc[rd_idx]  : '0;
      rd_alu_o   <= rd_hit ? mem_alu[rd_idx] : '0;
      rd_wb_o    <= rd_hit ? mem_wb[rd_idx]  : '0;
    end
  end

endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb_pipe_run_monitor: directed scenarios plus a randomized run, checked
// against a queue-based reference model of the run monitor.
module tb_pipe_run_monitor;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 32;
  localparam int unsigned MAXC  = 200;
  localparam int unsigned SL    = 8;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk, rst_n, en, clr, wbv;
  logic [DW-1:0] pc, instr, alu, wb;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_pc, rd_wb, rd_alu;
  logic          rd_valid, done;
  logic [CW-1:0] cycle_cnt, retire_cnt;
  logic [AW:0]   trace_cnt;
  logic [1:0]    cause;

  pipe_run_monitor #(
    .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .MAX_CYCLES(MAXC),
    .HALT_WORD(HALT), .STUCK_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clear_i(clr),
    .pc_i(pc), .instr_i(instr), .alu_i(alu), .wb_i(wb), .wb_valid_i(wbv),
    .rd_addr_i(rd_addr), .rd_pc_o(rd_pc), .rd_wb_o(rd_wb), .rd_alu_o(rd_alu),
    .rd_valid_o(rd_valid), .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt),
    .trace_cnt_o(trace_cnt), .done_o(done), .done_cause_o(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: trace kept as a queue, newest entry at the front
  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wb;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cyc, m_ret, m_run;
  logic        m_done;
  logic [1:0]  m_cause;
  logic [31:0] m_ppc;
  bit          m_pvalid;
  logic        e_rv;
  logic [31:0] e_pc, e_alu, e_wb;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cyc = 0; m_ret = 0; m_run = 0;
    m_done = 1'b0; m_cause = 2'd0;
    m_ppc = '0; m_pvalid = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    e_rv = 1'b0; e_pc = '0; e_alu = '0; e_wb = '0;
  endtask

  task automatic check_all();
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
    chk("trace_cnt", 64'(trace_cnt), 64'(mq.size()));
    chk("done", 64'(done), 64'(m_done));
    chk("cause", 64'(cause), 64'(m_cause));
    chk("rd_valid", 64'(rd_valid), 64'(e_rv));
    chk("rd_pc", 64'(rd_pc), 64'(e_pc));
    chk("rd_alu", 64'(rd_alu), 64'(e_alu));
    chk("rd_wb", 64'(rd_wb), 64'(e_wb));
  endtask

  // One clock: read expectation from pre-edge model, then apply the rules
  task automatic step();
    if (int'(rd_addr) < mq.size()) begin
      e_rv = 1'b1; e_pc = mq[rd_addr].pc; e_alu = mq[rd_addr].alu; e_wb = mq[rd_addr].wb;
    end else begin
      e_rv = 1'b0; e_pc = '0; e_alu = '0; e_wb = '0;
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_clear();
    end else if (!m_done && en) begin
      m_cyc++;
      if (wbv) begin
        mq.push_front('{pc, alu, wb});
        if (mq.size() > DEPTH) void'(mq.pop_back());
        m_ret++;
      end
      m_run = (m_pvalid && pc == m_ppc) ? m_run + 1 : 1;
      m_ppc = pc;
      m_pvalid = 1'b1;
      if (instr == HALT) begin
        m_done = 1'b1; m_cause = 2'd2;
      end else if (m_run == SL) begin
        m_done = 1'b1; m_cause = 2'd3;
      end else if (m_cyc == MAXC) begin
        m_done = 1'b1; m_cause = 2'd1;
      end
    end
    check_all();
  endtask

  task automatic go(input bit e, input bit c, input bit v, input logic [31:0] p,
                    input logic [31:0] ins, input logic [31:0] w);
    en = e; clr = c; wbv = v; pc = p; instr = ins; wb = w;
    alu = $urandom;
    rd_addr = AW'($urandom_range(0, DEPTH - 1));
    step();
  endtask

  function automatic logic [31:0] nonhalt();
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  task automatic do_clear();
    go(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic read_age(input int a);
    en = 1'b0; clr = 1'b0; wbv = 1'b0;
    rd_addr = AW'(a);
    step();
  endtask

  initial begin
    logic [31:0] p;
    rst_n = 1'b0; en = 0; clr = 0; wbv = 0;
    pc = '0; instr = '0; alu = '0; wb = '0; rd_addr = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cycle limit with a writeback every cycle; extra cycles must be ignored
    for (int i = 0; i < 210; i++) go(1, 0, 1, 32'h100 + 32'(4 * i), nonhalt(), $urandom);
    chk("lim_done", 64'(done), 64'd1);
    chk("lim_cause", 64'(cause), 64'd1);
    chk("lim_cycles", 64'(cycle_cnt), 64'd200);
    chk("lim_retire", 64'(retire_cnt), 64'd200);
    chk("lim_trace", 64'(trace_cnt), 64'd16);
    read_age(0);
    chk("lim_age0_pc", 64'(rd_pc), 64'(32'h100 + 32'(4 * 199)));

    // Clear from DONE, then halt on cycle 10
    do_clear();
    chk("clr_cycles", 64'(cycle_cnt), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    for (int i = 1; i <= 15; i++)
      go(1, 0, (i == 10) ? 1'b1 : 1'($urandom % 2), 32'h2000 + 32'(4 * i),
         (i == 10) ? HALT : nonhalt(), $urandom);
    chk("halt_cause", 64'(cause), 64'd2);
    chk("halt_cycles", 64'(cycle_cnt), 64'd10);
    read_age(0);
    chk("halt_age0_pc", 64'(rd_pc), 64'(32'h2000 + 32'd40));

    // Stuck PC: eight equal PCs stop the run on the eighth edge
    do_clear();
    for (int i = 0; i < 10; i++) go(1, 0, 1'($urandom % 2), 32'h40, nonhalt(), $urandom);
    chk("stuck_cause", 64'(cause), 64'd3);
    chk("stuck_cycles", 64'(cycle_cnt), 64'd8);

    // Seven equal, one change, seven equal: no stop; one more equal stops
    do_clear();
    for (int i = 0; i < 7; i++) go(1, 0, 0, 32'h40, nonhalt(), $urandom);
    go(1, 0, 0, 32'h44, nonhalt(), $urandom);
    for (int i = 0; i < 7; i++) go(1, 0, 0, 32'h40, nonhalt(), $urandom);
    chk("restart_no_stop", 64'(done), 64'd0);
    go(1, 0, 0, 32'h40, nonhalt(), $urandom);
    chk("restart_stuck", 64'(cause), 64'd3);
    chk("restart_cycles", 64'(cycle_cnt), 64'd16);

    // Wrap: 20 writebacks, wb = 1..20
    do_clear();
    for (int i = 1; i <= 20; i++) go(1, 0, 1, 32'h3000 + 32'(4 * i), nonhalt(), 32'(i));
    chk("wrap_trace", 64'(trace_cnt), 64'd16);
    read_age(0);
    chk("wrap_age0", 64'(rd_wb), 64'd20);
    read_age(15);
    chk("wrap_age15", 64'(rd_wb), 64'd5);
    do_clear();
    for (int i = 1; i <= 3; i++) go(1, 0, 1, 32'h3100 + 32'(4 * i), nonhalt(), 32'(i));
    read_age(3);
    chk("short_age3_valid", 64'(rd_valid), 64'd0);
    chk("short_age3_wb", 64'(rd_wb), 64'd0);
    read_age(2);
    chk("short_age2_wb", 64'(rd_wb), 64'd1);

    // Pause: counters frozen while disabled
    do_clear();
    for (int i = 0; i < 10; i++) go(1, 0, 1, 32'h4000 + 32'(4 * i), nonhalt(), $urandom);
    for (int i = 0; i < 5; i++) go(0, 0, 1, 32'h5000 + 32'(4 * i), nonhalt(), $urandom);
    chk("pause_cycles", 64'(cycle_cnt), 64'd10);
    chk("pause_retire", 64'(retire_cnt), 64'd10);

    // Asynchronous reset mid-run
    for (int i = 0; i < 4; i++) go(1, 0, 1, 32'h6000 + 32'(4 * i), nonhalt(), $urandom);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Halt, stuck and cycle limit all on cycle 200: halt wins
    for (int i = 1; i <= 200; i++)
      go(1, 0, 1, (i <= 192) ? 32'h1000 + 32'(4 * i) : 32'h40,
         (i == 200) ? HALT : nonhalt(), $urandom);
    chk("multi_cause", 64'(cause), 64'd2);
    chk("multi_cycles", 64'(cycle_cnt), 64'd200);

    // Randomized run with pauses, holds and occasional clears
    do_clear();
    p = 32'h8000;
    for (int i = 0; i < 700; i++) begin
      if ($urandom % 4 != 0) p = p + 32'd4;
      go(1'($urandom % 5 != 0), 1'($urandom % 90 == 0), 1'($urandom % 2), p,
         ($urandom % 150 == 0) ? HALT : nonhalt(), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_run_monitor.md
# pipe_run_monitor

Synthesizable run-control and trace monitor that sits beside the pipelined MIPS core and observes its PC, instruction, ALU result and writeback streams every cycle. It counts cycles and retirements, stops the run on a cycle limit, a halt instruction or a stuck PC, and records the most recent writebacks in a circular trace buffer. A read port makes the trace available to a debug host or bench after the run stops.

## Interface
- DATA_W, 32: width of PC, instruction, ALU and writeback words
- DEPTH, 16: trace entries; power of two, ≥2
- CNT_W, 32: width of cycle and retire counters
- MAX_CYCLES, 200: enabled-cycle limit before a forced stop
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that halts the run
- STUCK_LIMIT, 8: consecutive enabled cycles with an unchanged PC that count as stuck
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  1  run enable; when low, all monitor state holds
- clear_i  in  1  synchronous clear back to the post-reset state
- pc_i  in  DATA_W  core PC
- instr_i  in  DATA_W  core fetched instruction
- alu_i  in  DATA_W  core ALU result
- wb_i  in  DATA_W  core writeback data
- wb_valid_i  in  1  writeback/retire qualifier
- rd_addr_i  in  log2(DEPTH)  trace age index; 0 is the newest entry
- rd_pc_o  out  DATA_W  PC of the addressed entry
- rd_wb_o  out  DATA_W  writeback data of the addressed entry
- rd_alu_o  out  DATA_W  ALU result of the addressed entry
- rd_valid_o  out  1  addressed entry exists
- cycle_cnt_o  out  CNT_W  enabled cycles counted in RUN
- retire_cnt_o  out  CNT_W  captured writebacks
- trace_cnt_o  out  log2(DEPTH)+1  valid trace entries; saturates at DEPTH
- done_o  out  1  run stopped; sticky
- done_cause_o  out  2  0 none, 1 cycle limit, 2 halt word, 3 stuck PC

## Operation
- States:
  - RUN (reset state)
  - DONE (sticky; exited only by rst_n or clear_i)
- Active cycle: state is RUN, en_i = 1 and clear_i = 0. Nothing changes in any other cycle except through clear_i.
- Each active cycle:
  - cycle_cnt increments.
  - If wb_valid_i = 1: write {pc_i, alu_i, wb_i} at wr_ptr; wr_ptr increments modulo DEPTH; retire_cnt increments; trace_cnt increments and saturates at DEPTH, so the oldest entry is overwritten once the buffer is full.
- Stuck detection:
  - prev_pc and prev_valid register the PC on every active cycle.
  - stuck_cnt increments when prev_valid = 1 and pc_i == prev_pc; any other active cycle resets it to 0.
  - prev_valid is 0 after reset or clear, so the first active cycle never compares.
- Stop conditions, evaluated on each active cycle; the cycle that triggers a stop is still fully counted and captured:
  - Halt (cause 2): instr_i == HALT_WORD.
  - Stuck (cause 3): the incremented stuck_cnt == STUCK_LIMIT - 1, i.e. STUCK_LIMIT consecutive cycles share one PC.
  - Cycle limit (cause 1): the incremented cycle_cnt == MAX_CYCLES.
  - When several fire together, priority is halt > stuck > cycle limit.
- In DONE, counters, the trace buffer and done_cause hold regardless of en_i.
- clear_i has priority over everything. It zeroes all counters, pointers, prev_valid, done and cause, returns the state to RUN, and invalidates the trace; RAM contents need not be cleared.
- Read port:
  - physical index = (wr_ptr - 1 - rd_addr_i) mod DEPTH
  - rd_valid_o = rd_addr_i < trace_cnt
  - Both the index and rd_valid_o use the pre-edge wr_ptr and trace_cnt.
  - When rd_valid_o = 0, rd_pc_o, rd_alu_o and rd_wb_o are 0.
- Counters wrap at 2^CNT_W. MAX_CYCLES must be < 2^CNT_W.

## Timing
- Reset: all outputs are 0, state is RUN, all pointers and counters are 0.
- Counters and done_o/done_cause_o are registered. They reflect the active cycle one edge later.
- done_o rises on the edge that samples the stopping cycle.
  - With en_i held high from reset and no halt or stuck, done_o rises on edge MAX_CYCLES and cycle_cnt_o = MAX_CYCLES.
- Read port latency is 1 cycle: rd_*_o are registered from the rd_addr_i and state present at the previous edge.
  - A write and a read of age 0 in the same cycle return the previous newest entry.
- rst_n is asserted asynchronously and must be deasserted synchronously to clk.
- Reset mid-run discards the trace and returns to RUN immediately.

## Test plan
- Cycle limit: en_i = 1, pc_i increments by 4 each cycle, no halt, wb_valid_i = 1 every cycle → done_o = 1 after 200 edges; cause = 1; cycle_cnt_o = 200; retire_cnt_o = 200; trace_cnt_o = 16; age 0 gives pc = the 200th PC.
- Halt: instr_i = 32'hFFFF_FFFF on cycle 10 with wb_valid_i = 1 → done, cause = 2, cycle_cnt_o = 10; that entry is at age 0; later inputs are ignored.
- Stuck PC: pc_i held at 32'h40 for 8 cycles → cause 3 on the 8th edge; 7 equal cycles with a change on the 8th → no stop and stuck_cnt restarts.
- Wrap and read: 20 writebacks with wb_i = 1..20 → age 0 = 20, age 15 = 5; trace_cnt_o = 16; with 3 writebacks only, age 3 gives rd_valid_o = 0 and data 0.
- Pause, clear and reset: en_i low for 5 cycles mid-run → counters frozen. clear_i in DONE → RUN with all counters 0. rst_n pulsed mid-run → outputs go to 0 asynchronously.
- Simultaneous causes: halt word on the MAX_CYCLES-th cycle while the PC is also stuck → cause = 2.
